// File: rtl/aline_readout_sequencer.sv
// ---------------------------------------------------------------------------
// aline_readout_sequencer
//
// Read-side sequencer for the per-A-line sample buffer. After a start pulse
// it walks RAM addresses 0..NSAMPLES-1, absorbs the fixed RAM read latency
// and streams the samples downstream on a valid/ready interface, marking the
// first beat with out_sop and the last beat with out_eop.
//
// Reads are credit-limited: a read is issued only while
// (output FIFO occupancy + reads still in the RAM pipeline) < FIFO_DEPTH,
// so returning data always has room regardless of downstream backpressure.
//
// Ports
//   clock      acquisition clock, all logic on the rising edge
//   sclr       synchronous active-high clear, overrides every other input
//   start      one-cycle pulse: A-line complete, buffer ready to read
//   rd_en      RAM read enable
//   rd_addr    RAM read address
//   rd_data    RAM read data, valid RD_LATENCY cycles after rd_en
//   out_data   sample to downstream (FIFO head, show-ahead)
//   out_valid  out_data valid
//   out_ready  downstream accepts when high together with out_valid
//   out_sop    high with the first beat of a packet
//   out_eop    high with the last beat of a packet
//   busy       high while a packet is being read or drained
//   done       one-cycle pulse after the last beat handshake
//   overrun    sticky: start seen while busy; cleared only by sclr
// ---------------------------------------------------------------------------
module aline_readout_sequencer #(
    parameter logic [10:0] NSAMPLES   = 11'd1170,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              start,
    output logic              rd_en,
    output logic [10:0]       rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned      PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [10:0]      LAST_IDX   = NSAMPLES - 11'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // vld_sr[i] is set for a read issued i+1 cycles ago; the oldest stage
    // marks the cycle in which rd_data carries that read's word.
    logic [RD_LATENCY-1:0] vld_sr;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W-1:0]  in_flight;
    logic [10:0]       beat_cnt;

    logic push;
    logic pop;
    logic have_credit;
    logic accept;

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CNT_W'(vld_sr[i]);
        end
    end

    // Uses registered occupancy only: a beat consumed this cycle returns
    // its credit one cycle later, which keeps rd_en off the out_ready path.
    assign have_credit = (occ + in_flight) < CREDIT_MAX;

    // ------------------------------------------------------------------
    // Output side (show-ahead FIFO head)
    // ------------------------------------------------------------------
    assign push      = vld_sr[RD_LATENCY-1];
    assign out_valid = (occ != '0);
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign out_sop   = out_valid && (beat_cnt == 11'd0);
    assign out_eop   = out_valid && (beat_cnt == LAST_IDX);

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start;

    // ------------------------------------------------------------------
    // FSM next state / read enable
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                // Gated by sclr so a clear never launches a read whose data
                // would then be discarded anyway.
                rd_en = have_credit && !sclr;
                if (have_credit && (rd_addr == LAST_IDX)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_eop) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, address, pipeline tracking, FIFO pointers, beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (sclr) begin
            state    <= IDLE;
            rd_addr  <= '0;
            vld_sr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            beat_cnt <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) && pop && out_eop;

            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            // Address holds at the last index once it has been issued.
            if (accept) begin
                rd_addr <= '0;
            end else if (rd_en && (rd_addr != LAST_IDX)) begin
                rd_addr <= rd_addr + 11'd1;
            end

            vld_sr[0] <= rd_en;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end

            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
            end

            if (push && !pop) begin
                occ <= occ + CNT_ONE;
            end else if (!push && pop) begin
                occ <= occ - CNT_ONE;
            end

            if (accept) begin
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= out_eop ? '0 : beat_cnt + 11'd1;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rd_data;
        end
    end

endmodule

// File: tb/tb_aline_readout_sequencer.sv
module tb_aline_readout_sequencer;

    typedef struct {
        logic [10:0] addr;
        int          cyc;
    } addr_t;

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic sclr, start, out_ready;
    logic start_b, ready_b;

    // small instance (NSAMPLES = 8)
    logic        rd_en, out_valid, out_sop, out_eop, busy, done, overrun;
    logic [10:0] rd_addr;
    logic [15:0] rd_data, out_data, pipe;

    // large instance (NSAMPLES = 2047)
    logic        rd_en_b, out_valid_b, out_sop_b, out_eop_b, busy_b, done_b, overrun_b;
    logic [10:0] rd_addr_b;
    logic [15:0] rd_data_b, out_data_b, pipe_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    addr_t exp_addr[$];
    beat_t exp_beat[$];
    beat_t exp_beat_b[$];

    int rd_cnt = 0, outstanding = 0, done_cnt = 0, done_cyc = -1;
    int busy_rise = -1, busy_fall = -1;
    logic prev_busy = 1'b0, stalled = 1'b0;
    logic [31:0] held;
    int exp_addr_b = 0, beat_idx_b = 0, eop_idx_b = -1, done_cnt_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    aline_readout_sequencer #(
        .NSAMPLES(11'd8), .DATA_W(16), .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clock(clk), .sclr(sclr), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .busy(busy),
        .done(done), .overrun(overrun)
    );

    aline_readout_sequencer #(
        .NSAMPLES(11'd2047), .DATA_W(16), .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) dut_big (
        .clock(clk), .sclr(sclr), .start(start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(ready_b), .out_sop(out_sop_b), .out_eop(out_eop_b), .busy(busy_b),
        .done(done_b), .overrun(overrun_b)
    );

    // RAM models: word = address + 100, two-cycle read latency, junk otherwise
    always @(posedge clk) begin
        pipe      <= rd_en ? (16'(rd_addr) + 16'd100) : 16'hDEAD;
        rd_data   <= pipe;
        pipe_b    <= rd_en_b ? (16'(rd_addr_b) + 16'd100) : 16'hDEAD;
        rd_data_b <= pipe_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor / scoreboard for the small instance
    always @(negedge clk) begin
        addr_t a;
        beat_t b;
        if (sclr) begin
            outstanding = 0;
            stalled     = 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) begin
                    a = exp_addr.pop_front();
                    check("rd_addr", 32'(rd_addr), 32'(a.addr));
                    if (a.cyc >= 0) check("rd_cycle", 32'(cyc), 32'(a.cyc));
                end
                check("credit_limit", 32'(outstanding < 4), 32'd1);
                outstanding++;
            end
            if (stalled) check("stall_hold", 32'({out_valid, out_sop, out_eop, out_data}), held);
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(exp_beat.size() != 0), 32'd1);
                if (exp_beat.size() != 0) begin
                    b = exp_beat.pop_front();
                    check("beat_data", 32'(out_data), 32'(b.data));
                    check("beat_sop", 32'(out_sop), 32'(b.sop));
                    check("beat_eop", 32'(out_eop), 32'(b.eop));
                    if (b.cyc >= 0) check("beat_cycle", 32'(cyc), 32'(b.cyc));
                end
                outstanding--;
            end
            stalled = out_valid && !out_ready;
            held    = 32'({out_valid, out_sop, out_eop, out_data});
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !prev_busy) busy_rise = cyc;
        if (!busy && prev_busy) busy_fall = cyc;
        prev_busy = busy;
    end

    // Monitor / scoreboard for the large instance (downstream always ready)
    always @(negedge clk) begin
        beat_t b;
        if (!sclr) begin
            if (rd_en_b) begin
                check("big_rd_addr", 32'(rd_addr_b), 32'(exp_addr_b));
                exp_addr_b++;
            end
            if (out_valid_b && ready_b) begin
                check("big_beat_expected", 32'(exp_beat_b.size() != 0), 32'd1);
                if (exp_beat_b.size() != 0) begin
                    b = exp_beat_b.pop_front();
                    check("big_beat_data", 32'(out_data_b), 32'(b.data));
                    check("big_beat_sop", 32'(out_sop_b), 32'(b.sop));
                    check("big_beat_eop", 32'(out_eop_b), 32'(b.eop));
                end
                if (out_eop_b) eop_idx_b = beat_idx_b;
                beat_idx_b++;
            end
        end
        if (done_b) done_cnt_b++;
    end

    task automatic pulse_start(output int t);
        @(posedge clk); #1;
        start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Expected 8-word packet: addresses at t+1+i, beats at t+4+i when timed
    task automatic push_packet(input int t, input bit timed);
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back('{addr: 11'(i), cyc: timed ? t + 1 + i : -1});
            exp_beat.push_back('{data: 16'(100 + i), sop: (i == 0), eop: (i == 7),
                                 cyc: timed ? t + 4 + i : -1});
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_beat.size() != 0 || exp_addr.size() != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(exp_beat.size() + exp_addr.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, d0, n;
        sclr = 1'b1; start = 1'b0; out_ready = 1'b1; start_b = 1'b0; ready_b = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sop_eop", 32'({out_sop, out_eop}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_big_valid_busy", 32'({out_valid_b, busy_b, rd_en_b}), 32'd0);
        @(posedge clk); #1;
        sclr = 1'b0;
        repeat (2) @(posedge clk);

        // 1: streaming with out_ready high, exact timing
        d0 = done_cnt;
        pulse_start(t);
        push_packet(t, 1'b1);
        wait_drain("stream_drain", 100);
        check("stream_busy_rise", 32'(busy_rise), 32'(t + 1));
        check("stream_done_cycle", 32'(done_cyc), 32'(t + 12));
        check("stream_busy_fall", 32'(busy_fall), 32'(t + 12));
        check("stream_done_count", 32'(done_cnt - d0), 32'd1);
        check("stream_last_addr", 32'(rd_addr), 32'd7);

        // 1b: start in the same cycle as the done pulse is accepted
        d0 = done_cnt;
        pulse_start(t);
        push_packet(t, 1'b1);
        repeat (10) @(posedge clk);
        pulse_start(t2);
        push_packet(t2, 1'b1);
        wait_drain("b2b_drain", 100);
        check("b2b_start_cycle", 32'(t2), 32'(t + 12));
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_done_cycle", 32'(done_cyc), 32'(t2 + 12));
        check("b2b_no_overrun", 32'(overrun), 32'd0);

        // 2: out_ready toggling every cycle
        d0 = done_cnt;
        pulse_start(t);
        push_packet(t, 1'b0);
        n = 0;
        while (exp_beat.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            out_ready = !out_ready;
            n++;
        end
        out_ready = 1'b1;
        wait_drain("toggle_drain", 50);
        check("toggle_done_count", 32'(done_cnt - d0), 32'd1);

        // 3: out_ready low for 20 cycles after start
        d0 = done_cnt;
        out_ready = 1'b0;
        rd_cnt = 0;
        pulse_start(t);
        push_packet(t, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        check("stall_read_count", 32'(rd_cnt), 32'd4);
        check("stall_valid_held", 32'({out_valid, out_sop, out_data}), 32'({1'b1, 1'b1, 16'd100}));
        out_ready = 1'b1;
        wait_drain("stall_drain", 100);
        check("stall_done_count", 32'(done_cnt - d0), 32'd1);

        // 4: second start during a packet sets overrun, packet unaffected
        d0 = done_cnt;
        pulse_start(t);
        push_packet(t, 1'b1);
        repeat (3) @(posedge clk);
        pulse_start(t2);
        check("ovr_second_start_cycle", 32'(t2), 32'(t + 5));
        wait_drain("ovr_drain", 100);
        repeat (10) @(posedge clk);
        #1;
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_idle", 32'({busy, out_valid}), 32'd0);
        check("ovr_done_count", 32'(done_cnt - d0), 32'd1);
        pulse_start(t);
        push_packet(t, 1'b1);
        wait_drain("ovr_next_drain", 100);
        check("ovr_still_set", 32'(overrun), 32'd1);
        check("ovr_next_done_count", 32'(done_cnt - d0), 32'd2);

        // 5: sclr mid-packet discards in-flight reads
        d0 = done_cnt;
        pulse_start(t);
        push_packet(t, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        sclr = 1'b1;
        @(posedge clk); #1;
        sclr = 1'b0;
        exp_addr.delete();
        exp_beat.delete();
        @(negedge clk);
        check("clr_rd_en", 32'(rd_en), 32'd0);
        check("clr_rd_addr", 32'(rd_addr), 32'd0);
        check("clr_out", 32'({out_valid, out_sop, out_eop}), 32'd0);
        check("clr_busy_done", 32'({busy, done}), 32'd0);
        check("clr_overrun", 32'(overrun), 32'd0);
        repeat (10) @(posedge clk);
        pulse_start(t);
        push_packet(t, 1'b1);
        wait_drain("clr_fresh_drain", 100);
        check("clr_done_count", 32'(done_cnt - d0), 32'd1);

        // 6: maximum packet length on the large instance
        exp_addr_b = 0;
        beat_idx_b = 0;
        eop_idx_b  = -1;
        for (int i = 0; i < 2047; i++) begin
            exp_beat_b.push_back('{data: 16'(100 + i), sop: (i == 0), eop: (i == 2046), cyc: -1});
        end
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (exp_beat_b.size() != 0 && n < 2300) begin
            @(posedge clk);
            n++;
        end
        check("big_drain", 32'(exp_beat_b.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("big_eop_index", 32'(eop_idx_b), 32'd2046);
        check("big_last_addr", 32'(rd_addr_b), 32'd2046);
        check("big_read_count", 32'(exp_addr_b), 32'd2047);
        check("big_done_count", 32'(done_cnt_b), 32'd1);
        check("big_idle", 32'({busy_b, overrun_b}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
